// File: rtl/int_mul_seq_if.sv
// ---------------------------------------------------------------------------
// int_mul_seq_if
// Handshake bundle for the sequential multiplier.
//   in_valid / in_ready : operand handshake (a, b)
//   a, b                : multiplicand / multiplier, width bits
//   out_valid/out_ready : result handshake
//   out                 : low width bits of a*b
// Modports:
//   master : the producer/consumer side (drives operands, accepts results)
//   slave  : the multiplier side
// ---------------------------------------------------------------------------
interface int_mul_seq_if #(
    parameter int width = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] out;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/int_mul_seq.sv
// ---------------------------------------------------------------------------
// int_mul_seq
// Sequential shift-and-add multiplier returning the low width bits of a*b
// (same bit pattern for unsigned and two's-complement operands). One
// operation in flight; the running sum is formed by a chunked_add instance.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, aborts any operation to IDLE
//   bus  : int_mul_seq_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/out)
//
// Timing: operands accepted on edge T, width BUSY updates on edges
// T+1..T+width, result registered and out_valid raised on edge T+width+1,
// held until out_ready is seen high while out_valid is high.
//
// Optional feature: define INT_MUL_SEQ_EARLY_TERM_EN to leave BUSY as soon
// as the remaining multiplier bits are all zero (result is unchanged).
//
// Also contains chunked_add: a combinational adder built from carry-linked
// chunks; width must be a multiple of chunk_width.
// ---------------------------------------------------------------------------
module chunked_add #(
    parameter int width       = 32,
    parameter int chunk_width = 8
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] out
);
    localparam int N_CHUNKS = width / chunk_width;

    // carry[gi] is the carry into chunk gi; carry-out of the top chunk is dropped
    logic [N_CHUNKS-1:0] carry;
    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < N_CHUNKS; gi++) begin : g_chunk
        localparam int LO = gi * chunk_width;
        if (gi == N_CHUNKS - 1) begin : g_top
            assign out[LO +: chunk_width] = a[LO +: chunk_width] + b[LO +: chunk_width]
                                            + chunk_width'(carry[gi]);
        end else begin : g_mid
            assign {carry[gi+1], out[LO +: chunk_width]} =
                {1'b0, a[LO +: chunk_width]} + {1'b0, b[LO +: chunk_width]}
                + (chunk_width + 1)'(carry[gi]);
        end
    end
endmodule

module int_mul_seq #(
    parameter int width = 32
) (
    input  logic          clk,
    input  logic          rst,
    int_mul_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(width) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [width-1:0] a_reg;
    logic [width-1:0] b_reg;
    logic [width-1:0] acc_reg;
    logic [CNT_W-1:0] count_reg;
    logic             out_valid_reg;
    logic [width-1:0] out_reg;

    logic [width-1:0] sum_next;
    logic [width-1:0] b_shift_next;
    logic             last_busy;

    chunked_add #(.width(width)) u_add (
        .a   (acc_reg),
        .b   (a_reg),
        .out (sum_next)
    );

    assign b_shift_next = b_reg >> 1;

`ifdef INT_MUL_SEQ_EARLY_TERM_EN
    // Once no multiplier bits remain, further cycles cannot change acc.
    assign last_busy = (count_reg == CNT_W'(width - 1)) || (b_shift_next == '0);
`else
    assign last_busy = (count_reg == CNT_W'(width - 1));
`endif

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.out       = out_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        acc_reg   <= '0;
                        count_reg <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (b_reg[0]) begin
                        acc_reg <= sum_next;
                    end
                    a_reg     <= a_reg << 1;
                    b_reg     <= b_shift_next;
                    count_reg <= count_reg + CNT_W'(1);
                    if (last_busy) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result; afterwards wait
                    // for the consumer with out/out_valid held stable.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        out_reg       <= acc_reg;
                    end else if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule
